// File: rtl/vid_scaler.sv
// vid_scaler: maps a raster pixel stream onto a DST_W x DST_H address grid.
// Stretch mode scales coordinates by DST/SRC. Wrap mode takes them modulo DST.
// Both modes use stepping accumulators and counters only.
// A two-state lock FSM tracks the raster sequence. Only pixels accepted while
// in sequence produce an address, two cycles after pix_en.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   pix_en                pixel strobe
//   pixel_column/row      source coordinates (PW bits)
//   mode                  0 = stretch, 1 = wrap (latched at pixel (0,0))
//   vid_addr              {dst_row, dst_col}, registered
//   out_valid             vid_addr valid this cycle
//   sync_lost             sequence violation seen, waiting for (0,0)
module vid_scaler #(
    parameter int unsigned SRC_W = 1024,
    parameter int unsigned SRC_H = 768,
    parameter int unsigned DST_W = 128,
    parameter int unsigned DST_H = 128,
    parameter int unsigned PW    = 12,
    localparam int unsigned CW   = $clog2(DST_W),
    localparam int unsigned RW   = $clog2(DST_H)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pix_en,
    input  logic [PW-1:0]     pixel_column,
    input  logic [PW-1:0]     pixel_row,
    input  logic              mode,
    output logic [RW+CW-1:0]  vid_addr,
    output logic              out_valid,
    output logic              sync_lost
);

    // Accumulators hold a remainder below SRC, plus one DST step of headroom.
    localparam int unsigned AW = $clog2(SRC_W + SRC_H + DST_W + DST_H) + 1;

    typedef enum logic {UNSYNC = 1'b0, LOCKED = 1'b1} state_t;

    state_t          state_q;
    logic [PW-1:0]   last_c_q, last_r_q;
    logic [AW-1:0]   acc_c_q, acc_r_q, acc_c_d, acc_r_d, acc_c_sum, acc_r_sum;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic            mode_q;
    logic            s1_valid_q;
    logic            is_origin, row_end, frame_end, step_col, step_row, legal;

    // Sequence check against the last accepted pixel, and next scaled position.
    always_comb begin
        is_origin = (pixel_column == '0) && (pixel_row == '0);
        row_end   = (last_c_q == PW'(SRC_W - 1));
        frame_end = row_end && (last_r_q == PW'(SRC_H - 1));
        step_col  = !row_end && (pixel_column == last_c_q + PW'(1))
                    && (pixel_row == last_r_q);
        step_row  = row_end && !frame_end && (pixel_column == '0)
                    && (pixel_row == last_r_q + PW'(1));
        if (state_q == LOCKED) begin
            legal = step_col || step_row || (frame_end && is_origin);
        end else begin
            legal = is_origin;
        end

        acc_c_sum = acc_c_q + AW'(DST_W);
        acc_r_sum = acc_r_q + AW'(DST_H);
        col_d     = '0;
        row_d     = '0;
        acc_c_d   = '0;
        acc_r_d   = '0;

        if (is_origin) begin
            // Frame start: everything restarts at zero in either mode.
        end else if (step_col) begin
            row_d   = row_q;
            acc_r_d = acc_r_q;
            if (mode_q) begin
                acc_c_d = acc_c_q;
                col_d   = (col_q == CW'(DST_W - 1)) ? '0 : col_q + CW'(1);
            end else if (acc_c_sum >= AW'(SRC_W)) begin
                acc_c_d = acc_c_sum - AW'(SRC_W);
                col_d   = col_q + CW'(1);
            end else begin
                acc_c_d = acc_c_sum;
                col_d   = col_q;
            end
        end else if (step_row) begin
            // Column side restarts at zero; only the row side steps.
            if (mode_q) begin
                acc_r_d = acc_r_q;
                row_d   = (row_q == RW'(DST_H - 1)) ? '0 : row_q + RW'(1);
            end else if (acc_r_sum >= AW'(SRC_H)) begin
                acc_r_d = acc_r_sum - AW'(SRC_H);
                row_d   = row_q + RW'(1);
            end else begin
                acc_r_d = acc_r_sum;
                row_d   = row_q;
            end
        end
    end

    // Lock FSM, scaling state and two-stage output pipeline.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= UNSYNC;
            last_c_q   <= '0;
            last_r_q   <= '0;
            acc_c_q    <= '0;
            acc_r_q    <= '0;
            col_q      <= '0;
            row_q      <= '0;
            mode_q     <= 1'b0;
            s1_valid_q <= 1'b0;
            vid_addr   <= '0;
            out_valid  <= 1'b0;
            sync_lost  <= 1'b0;
        end else begin
            s1_valid_q <= 1'b0;
            out_valid  <= s1_valid_q;
            if (s1_valid_q) begin
                vid_addr <= {row_q, col_q};
            end
            if (pix_en) begin
                if (legal) begin
                    state_q    <= LOCKED;
                    sync_lost  <= 1'b0;
                    s1_valid_q <= 1'b1;
                    last_c_q   <= pixel_column;
                    last_r_q   <= pixel_row;
                    acc_c_q    <= acc_c_d;
                    acc_r_q    <= acc_r_d;
                    col_q      <= col_d;
                    row_q      <= row_d;
                    if (is_origin) begin
                        mode_q <= mode;
                    end
                end else if (state_q == LOCKED) begin
                    state_q   <= UNSYNC;
                    sync_lost <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vid_scaler.sv
// Scoreboard bench for vid_scaler on a reduced 40x30 -> 16x8 raster.
// The stimulus side pushes expected addresses. A negedge monitor pops them and
// checks value and arrival cycle.
module tb_vid_scaler;

    localparam int unsigned SW = 40;
    localparam int unsigned SH = 30;
    localparam int unsigned DW = 16;
    localparam int unsigned DH = 8;
    localparam int unsigned PW = 12;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          pix_en;
    logic [PW-1:0] pixel_column, pixel_row;
    logic          mode;
    logic [6:0]    vid_addr;
    logic          out_valid;
    logic          sync_lost;

    vid_scaler #(.SRC_W(SW), .SRC_H(SH), .DST_W(DW), .DST_H(DH), .PW(PW)) dut (
        .clk(clk), .reset_n(reset_n), .pix_en(pix_en),
        .pixel_column(pixel_column), .pixel_row(pixel_row), .mode(mode),
        .vid_addr(vid_addr), .out_valid(out_valid), .sync_lost(sync_lost)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned due;
        logic [6:0]  addr;
        int          r;
        int          c;
        logic        m;
    } exp_t;

    typedef struct {
        logic       m;
        int         r;
        int         c;
        logic [6:0] a;
    } spot_t;

    // Hand-computed addresses: row<<4 | col.
    spot_t spots [0:9] = '{
        '{1'b0, 0, 0, 7'd0},   '{1'b0, 0, 7, 7'd2},   '{1'b0, 3, 4, 7'd1},
        '{1'b0, 4, 5, 7'd18},  '{1'b0, 11, 25, 7'd42}, '{1'b0, 29, 39, 7'd127},
        '{1'b1, 0, 16, 7'd0},  '{1'b1, 9, 17, 7'd17}, '{1'b1, 11, 25, 7'd57},
        '{1'b1, 29, 39, 7'd87}
    };

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference sequence tracker.
    bit   m_locked = 1'b0;
    int   m_lr = 0, m_lc = 0;
    logic m_mode = 1'b0;

    function automatic logic [6:0] exp_addr(input int r, input int c, input logic m);
        int dr, dc;
        if (m) begin
            dr = r % DH;
            dc = c % DW;
        end else begin
            dr = (r * DH) / SH;
            dc = (c * DW) / SW;
        end
        return {3'(dr), 4'(dc)};
    endfunction

    task automatic chk(input string name, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    task automatic pix(input int r, input int c);
        bit ok;
        @(negedge clk);
        pix_en       = 1'b1;
        pixel_row    = PW'(r);
        pixel_column = PW'(c);
        if (!m_locked)                  ok = (r == 0 && c == 0);
        else if (m_lc < int'(SW) - 1)   ok = (c == m_lc + 1 && r == m_lr);
        else if (m_lr < int'(SH) - 1)   ok = (c == 0 && r == m_lr + 1);
        else                            ok = (r == 0 && c == 0);
        if (ok) begin
            if (r == 0 && c == 0) m_mode = mode;
            m_locked = 1'b1;
            m_lr = r;
            m_lc = c;
            sb.push_back('{cyc + 2, exp_addr(r, c, m_mode), r, c, m_mode});
        end else begin
            m_locked = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            pix_en = 1'b0;
        end
    endtask

    task automatic run(input int p0, input int p1, input bit gaps, input int toggle_r);
        for (int p = p0; p <= p1; p++) begin
            int r, c;
            r = p / int'(SW);
            c = p % int'(SW);
            if (r == toggle_r && c == 0) mode = ~mode;
            pix(r, c);
            if (gaps) idle(int'($urandom_range(1, 3)));
        end
    endtask

    // Monitor: every out_valid must match the oldest pending entry on its due cycle.
    always @(negedge clk) begin
        if (out_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_valid: addr %0d at cycle %0d, nothing pending",
                         vid_addr, cyc);
            end else begin
                mon_e = sb.pop_front();
                n_cmp++;
                if (mon_e.due != cyc || vid_addr !== mon_e.addr) begin
                    n_err++;
                    $display("FAIL pix_r%0d_c%0d: got addr %0d at cycle %0d, want addr %0d at cycle %0d",
                             mon_e.r, mon_e.c, vid_addr, cyc, mon_e.addr, mon_e.due);
                end
                foreach (spots[i]) begin
                    if (spots[i].m == mon_e.m && spots[i].r == mon_e.r && spots[i].c == mon_e.c) begin
                        n_cmp++;
                        if (vid_addr !== spots[i].a) begin
                            n_err++;
                            $display("FAIL spot_m%0d_r%0d_c%0d: got addr %0d, want %0d",
                                     spots[i].m, spots[i].r, spots[i].c, vid_addr, spots[i].a);
                        end
                    end
                end
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL missing_r%0d_c%0d: out_valid low at cycle %0d, want addr %0d",
                     mon_e.r, mon_e.c, cyc, mon_e.addr);
        end
    end

    initial begin
        reset_n      = 1'b0;
        pix_en       = 1'b0;
        pixel_column = '0;
        pixel_row    = '0;
        mode         = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_addr", int'(vid_addr), 0);
        chk("reset_valid", int'(out_valid), 0);
        chk("reset_sync_lost", int'(sync_lost), 0);
        @(posedge clk);
        #2 reset_n = 1'b1;

        // Non-origin pixels while unsynced produce nothing.
        pix(5, 5);
        pix(0, 3);
        idle(3);
        chk("unsync_sync_lost", int'(sync_lost), 0);

        // Frame A: stretch, back-to-back; frame B: gapped, mode flips mid-frame.
        run(0, SW * SH - 1, 1'b0, -1);
        run(0, SW * SH - 1, 1'b1, 10);

        // Frame C: wrap, then a column jump at row 5.
        run(0, 5 * SW + 10, 1'b0, -1);
        pix(5, 20);
        pix(5, 21);
        idle(2);
        chk("jump_sync_lost", int'(sync_lost), 1);
        chk("jump_valid", int'(out_valid), 0);

        // Relock at (0,0) and complete frame D in wrap.
        pix(0, 0);
        idle(1);
        chk("relock_sync_lost", int'(sync_lost), 0);
        run(1, SW * SH - 1, 1'b0, -1);

        // Frame E interrupted by asynchronous reset with pixels in flight.
        run(0, 20 * SW + 30, 1'b0, -1);
        @(posedge clk);
        #2;
        sb.delete();
        reset_n  = 1'b0;
        m_locked = 1'b0;
        m_mode   = 1'b0;
        #1;
        chk("async_reset_addr", int'(vid_addr), 0);
        chk("async_reset_valid", int'(out_valid), 0);
        chk("async_reset_sync_lost", int'(sync_lost), 0);
        @(negedge clk);
        pix_en = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 reset_n = 1'b1;

        mode = 1'b0;
        run(20 * SW + 33, 20 * SW + 40, 1'b0, -1);
        idle(3);
        chk("post_reset_sync_lost", int'(sync_lost), 0);
        chk("post_reset_valid", int'(out_valid), 0);
        run(0, 2 * SW + 5, 1'b1, -1);
        idle(6);
        chk("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vid_scaler.md
VID_SCALER -- requirements
Module: vid_scaler

Interface
REQ-001 Parameter SRC_W, default 1024, source frame width in pixels.
REQ-002 Parameter SRC_H, default 768, source frame height in pixels.
REQ-003 Parameter DST_W, default 128, destination map width; CW = clog2(DST_W).
REQ-004 Parameter DST_H, default 128, destination map height; RW = clog2(DST_H).
REQ-005 Parameter PW, default 12, pixel coordinate width.
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 pix_en  input  1  pixel strobe; coordinates valid this cycle.
REQ-009 pixel_column  input  PW  source column.
REQ-010 pixel_row  input  PW  source row.
REQ-011 mode  input  1  0 = stretch (DST/SRC ratio), 1 = wrap (coordinate mod DST).
REQ-012 vid_addr  output  RW+CW  {dst_row, dst_col}, registered.
REQ-013 out_valid  output  1  vid_addr valid this cycle.
REQ-014 sync_lost  output  1  raster sequence violation detected, waiting for relock.

Function
REQ-015 Scaling SHALL be incremental (accumulator/counter stepping); no divider or multiplier by a non-constant SHALL be used.
REQ-016 Stretch: dst_col = floor(c*DST_W/SRC_W), dst_row = floor(r*DST_H/SRC_H), exact for all c < SRC_W, r < SRC_H.
REQ-017 Wrap: dst_col = c mod DST_W, dst_row = r mod DST_H.
REQ-018 Latency: pix_en in cycle N -> out_valid and matching vid_addr in cycle N+2; pipeline is fully pipelined, accepting pix_en every cycle.
REQ-019 out_valid SHALL be high only for pix_en pixels accepted in state LOCKED; otherwise low, vid_addr holds its last value.
REQ-020 FSM states: UNSYNC, LOCKED.
REQ-021 UNSYNC -> LOCKED on pix_en with column 0 and row 0; that pixel is output (addr 0).
REQ-022 Legal steps in LOCKED: (c+1, r) with c+1 < SRC_W; (0, r+1) after c = SRC_W-1 with r+1 < SRC_H; (0, 0) after (SRC_W-1, SRC_H-1).
REQ-023 Any other pix_en coordinate in LOCKED -> UNSYNC, sync_lost set, that pixel not output.
REQ-024 sync_lost cleared on relock (REQ-021); stays low when UNSYNC is entered from reset.
REQ-025 Cycles without pix_en SHALL not advance any accumulator or counter.
REQ-026 mode SHALL be sampled only at pixel (0,0) when locking or wrapping frames; changes mid-frame take effect next frame.
REQ-027 Column accumulator resets at every column 0; row accumulator advances only on row change, resets at row 0.
REQ-028 Coordinates >= SRC_W or >= SRC_H are sequence violations (REQ-023).

Reset
REQ-029 While reset_n low: state UNSYNC, vid_addr = 0, out_valid = 0, sync_lost = 0, accumulators 0, latched mode = 0, pipeline emptied.
REQ-030 Reset asserted mid-frame SHALL discard in-flight pixels; no out_valid until relock at (0,0).

Verification
REQ-031 Full 1024x768 raster, mode 0 -> (r 0,c 7) addr 0; (r 6,c 8) addr 129; (r 12,c 17) addr 258; (r 767,c 1023) addr 16383; each exactly 2 cycles after pix_en.
REQ-032 Full raster, mode 1 -> (r 130,c 200) addr 328; (r 0,c 128) addr 0; (r 767,c 1023) addr 0x3FFF&((767 mod 128)<<7 | 127) = 16383.
REQ-033 Raster with jump (r 5,c 10)->(r 5,c 40) -> out_valid low from c 40 on, sync_lost 1; next (0,0) -> out_valid 1, addr 0, sync_lost 0.
REQ-034 pix_en gapped randomly (1-3 idle cycles) across full frame, mode 0 -> addresses identical to REQ-031 reference, no out_valid on idle cycles.
REQ-035 reset_n pulsed low at (r 300,c 500) -> outputs 0 asynchronously; no out_valid until (0,0); sync_lost stays 0.
REQ-036 mode toggled 0->1 at (r 100,c 0) -> frame continues in stretch; wrap results from next (0,0).
